keypad_operand_entry: RTL and testbench
=======================================

// Module: keypad_operand_entry
// PURPOSE
//  Parametrised keypad-to-operand collector for the calculator datapath. Accepts 4-bit
//  scan codes from the keypad scanner, builds two BCD operands of DIGITS digits plus
//  an operator code, supports backspace, and commits {a,b,op} through a valid/ready
//  output register to the ALU/display stage. Keys arriving while a commit is pending
//  are still collected into the next entry.
// PARAMETERS
//  DIGITS   4   BCD digits per operand; operand width OW = 4*DIGITS
//  OP_W     2   operator code width (codes 3,7,11,15 map to op 0..3)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  key_valid  in   1       one-cycle strobe: key_code valid this cycle
//  key_code   in   4       scanner code
//  a          out  OW      committed operand A, BCD, digit 0 = LSD
//  b          out  OW      committed operand B, BCD
//  op         out  OP_W    committed operator
//  out_valid  out  1       {a,b,op} hold a committed, unconsumed result
//  out_ready  in   1       consumer accepts; transfer when out_valid && out_ready
//  ovf        out  1       sticky: a digit was dropped because the operand was full
//  err        out  1       one-cycle pulse: commit rejected
//  state_o    out  2       current entry state, for debug/display
// BEHAVIOUR
//  Reset (async, rst=1): a=b=0, op=0, out_valid=0, ovf=0, err=0, state=ENT_A,
//   entry registers, digit counts and pending op cleared. Reset mid-entry discards
//   everything.
//  Key map: 0,1,2->1,2,3; 4,5,6->4,5,6; 8,9,10->7,8,9; 13->0; 12 '*' = BACKSPACE;
//   3,7,11,15 = OP 0..3; 14 '#' = COMMIT. key_valid=0 means no action.
//  All updates land on the clk edge after the key_valid strobe (1-cycle latency).
//  States: ENT_A (building A), ENT_B (building B).
//  DIGIT: shift the active operand left one nibble and insert the digit; cnt++.
//   If cnt==DIGITS, no shift occurs, the digit is dropped, and ovf is set.
//   Leading zeros count as digits.
//  BACKSPACE: shift the active operand right one nibble; cnt--.
//   In ENT_B with cnt_b==0: go to ENT_A and clear the pending op.
//   In ENT_A with cnt_a==0: no-op.
//  OP: in ENT_A, latch op_pend and go to ENT_B. In ENT_B, replace op_pend and stay.
//  COMMIT: accepted only in ENT_B and only if (!out_valid || out_ready) this cycle.
//   On accept: a<=ent_a, b<=ent_b, op<=op_pend, out_valid<=1; clear entries, counts
//   and ovf; state<=ENT_A.
//   Otherwise: err pulses for 1 cycle and the entry is retained unchanged.
//  Output handshake: out_valid is cleared on out_valid && out_ready unless a commit is
//   accepted in the same cycle, in which case out_valid stays 1 with the new data.
//   a/b/op are stable while out_valid=1 and out_ready=0.
//  Widths: counts are $clog2(DIGITS+1) bits. BCD values are never re-checked; only
//   codes 0..9 are inserted.
// STRUCTURE
//  Package keypad_pkg: key-code localparams (KEY_BS=12, KEY_COMMIT=14, op codes) and
//   the state encoding ENT_A=0, ENT_B=1.
//  Sub-module keypad_bcd_entry_reg #(DIGITS): shift/insert/backspace register with
//   digit count and full flag. Instantiate it twice (A and B). The top level holds the
//   FSM, op_pend and the output register.
// TESTING
//  1 Keys 0,1 (->"12"), 3 (op0), 4 (->"4"), 14 -> next cycle a=0x0012, b=0x0004,
//    op=0, out_valid=1.
//  2 DIGITS=4: enter 1,2,3,4,5 into A -> ent_a=0x1234, ovf=1. Then op, 1, commit
//    -> a=0x1234, ovf=0.
//  3 Keys "7",op1,BACKSPACE,BACKSPACE -> state ENT_A, pending op cleared, ent_a=0.
//    One more BACKSPACE -> no change.
//  4 out_ready=0: commit #1 accepted. Enter second expression and commit -> err=1
//    for 1 cycle, outputs unchanged. Raise out_ready, commit again -> second result
//    appears; out_valid stays 1.
//  5 Commit in ENT_A -> err pulse, no output change. Assert rst mid-entry of B ->
//    all outputs 0 and state ENT_A immediately (asynchronous).

Source files
------------

// File: rtl/keypad_operand_entry_pkg.sv
// Shared key codes, entry-state encoding and scan-code decoder for the operand collector.
package keypad_pkg;

    localparam int unsigned KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_BS     = 4'd12;
    localparam logic [KEY_W-1:0] KEY_COMMIT = 4'd14;
    localparam logic [KEY_W-1:0] KEY_OP0    = 4'd3;
    localparam logic [KEY_W-1:0] KEY_OP1    = 4'd7;
    localparam logic [KEY_W-1:0] KEY_OP2    = 4'd11;
    localparam logic [KEY_W-1:0] KEY_OP3    = 4'd15;

    typedef enum logic [1:0] {
        ENT_A = 2'd0,
        ENT_B = 2'd1
    } entry_state_e;

    typedef enum logic [2:0] {
        KC_NONE,
        KC_DIGIT,
        KC_OP,
        KC_BS,
        KC_COMMIT
    } key_kind_e;

    typedef struct packed {
        key_kind_e  kind;
        logic [3:0] digit;
        logic [1:0] op_idx;
    } key_dec_t;

    // Classify a scanner code; op index is the row of the right-hand key column.
    function automatic key_dec_t decode_key(input logic [KEY_W-1:0] code);
        key_dec_t d;
        d.kind   = KC_NONE;
        d.digit  = 4'd0;
        d.op_idx = code[3:2];
        case (code)
            4'd0:  begin d.kind = KC_DIGIT; d.digit = 4'd1; end
            4'd1:  begin d.kind = KC_DIGIT; d.digit = 4'd2; end
            4'd2:  begin d.kind = KC_DIGIT; d.digit = 4'd3; end
            4'd4:  begin d.kind = KC_DIGIT; d.digit = 4'd4; end
            4'd5:  begin d.kind = KC_DIGIT; d.digit = 4'd5; end
            4'd6:  begin d.kind = KC_DIGIT; d.digit = 4'd6; end
            4'd8:  begin d.kind = KC_DIGIT; d.digit = 4'd7; end
            4'd9:  begin d.kind = KC_DIGIT; d.digit = 4'd8; end
            4'd10: begin d.kind = KC_DIGIT; d.digit = 4'd9; end
            4'd13: begin d.kind = KC_DIGIT; d.digit = 4'd0; end
            KEY_OP0, KEY_OP1, KEY_OP2, KEY_OP3: d.kind = KC_OP;
            KEY_BS:     d.kind = KC_BS;
            KEY_COMMIT: d.kind = KC_COMMIT;
            default:    d.kind = KC_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_operand_entry_if.sv
// Keypad input strobe plus committed-result valid/ready bus.
interface keypad_operand_entry_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OP_W   = 2
);
    localparam int unsigned OW = 4 * DIGITS;

    logic            key_valid;
    logic [3:0]      key_code;
    logic [OW-1:0]   a;
    logic [OW-1:0]   b;
    logic [OP_W-1:0] op;
    logic            out_valid;
    logic            out_ready;
    logic            ovf;
    logic            err;
    logic [1:0]      state_o;

    // Keypad scanner / consumer side.
    modport master (
        output key_valid, key_code, out_ready,
        input  a, b, op, out_valid, ovf, err, state_o
    );

    // Operand collector side.
    modport slave (
        input  key_valid, key_code, out_ready,
        output a, b, op, out_valid, ovf, err, state_o
    );

endinterface

// File: rtl/keypad_operand_entry_bcd_entry_reg.sv
// One BCD operand being typed: shift-in digits at the LSD, backspace drops the LSD.
module keypad_bcd_entry_reg #(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned OW     = 4 * DIGITS,
    localparam int unsigned CW     = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [3:0]    digit_i,
    input  logic          pop_i,
    output logic [OW-1:0] val_o,
    output logic          full_c,
    output logic          empty_c
);

    logic [OW-1:0] val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full_c  = (cnt_q == CW'(DIGITS));
    assign empty_c = (cnt_q == '0);
    assign val_o   = val_q;

    // Clear wins; a push into a full register or a pop from an empty one is ignored.
    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            val_d = '0;
            cnt_d = '0;
        end else if (push_i && !full_c) begin
            val_d = (val_q << 4) | OW'(digit_i);
            cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !empty_c) begin
            val_d = val_q >> 4;
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Operand and digit-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand collector: builds A, operator and B, then commits {a,b,op} via valid/ready.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OP_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    keypad_operand_entry_if.slave  bus
);

    localparam int unsigned OW = 4 * DIGITS;

    entry_state_e    state_q, state_d;
    logic [OP_W-1:0] op_pend_q, op_pend_d;
    logic [OW-1:0]   a_q, a_d, b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            out_valid_q, out_valid_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;

    logic            a_push, a_pop, b_push, b_pop, ent_clr;
    logic [OW-1:0]   ent_a, ent_b;
    logic            a_full, a_empty, b_full, b_empty;
    key_dec_t        dec;

    assign dec = decode_key(bus.key_code);

    keypad_bcd_entry_reg #(.DIGITS(DIGITS)) u_ent_a (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (ent_clr),
        .push_i  (a_push),
        .digit_i (dec.digit),
        .pop_i   (a_pop),
        .val_o   (ent_a),
        .full_c  (a_full),
        .empty_c (a_empty)
    );

    keypad_bcd_entry_reg #(.DIGITS(DIGITS)) u_ent_b (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (ent_clr),
        .push_i  (b_push),
        .digit_i (dec.digit),
        .pop_i   (b_pop),
        .val_o   (ent_b),
        .full_c  (b_full),
        .empty_c (b_empty)
    );

    // Next-state, entry control and output-register updates for one key strobe.
    always_comb begin
        state_d     = state_q;
        op_pend_d   = op_pend_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        ovf_d       = ovf_q;
        err_d       = 1'b0;
        a_push      = 1'b0;
        a_pop       = 1'b0;
        b_push      = 1'b0;
        b_pop       = 1'b0;
        ent_clr     = 1'b0;

        if (bus.key_valid) begin
            case (dec.kind)
                KC_DIGIT: begin
                    if (state_q == ENT_A) begin
                        if (a_full) ovf_d  = 1'b1;
                        else        a_push = 1'b1;
                    end else begin
                        if (b_full) ovf_d  = 1'b1;
                        else        b_push = 1'b1;
                    end
                end
                KC_BS: begin
                    if (state_q == ENT_A) begin
                        a_pop = !a_empty;
                    end else if (b_empty) begin
                        // Backing out of an empty B reopens A and forgets the operator.
                        state_d   = ENT_A;
                        op_pend_d = '0;
                    end else begin
                        b_pop = 1'b1;
                    end
                end
                KC_OP: begin
                    op_pend_d = OP_W'(dec.op_idx);
                    state_d   = ENT_B;
                end
                KC_COMMIT: begin
                    if (state_q == ENT_B && (!out_valid_q || bus.out_ready)) begin
                        a_d         = ent_a;
                        b_d         = ent_b;
                        op_d        = op_pend_q;
                        out_valid_d = 1'b1;
                        ovf_d       = 1'b0;
                        ent_clr     = 1'b1;
                        op_pend_d   = '0;
                        state_d     = ENT_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, pending operator and committed-output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENT_A;
            op_pend_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_pend_q   <= op_pend_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.op        = op_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry with a scoreboard-driven result monitor.
module tb_keypad_operand_entry;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned OP_W   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keypad_operand_entry_if #(.DIGITS(DIGITS), .OP_W(OP_W)) bus ();

    keypad_operand_entry #(.DIGITS(DIGITS), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected results in commit order: {a[15:0], b[15:0], op[1:0]}.
    logic [33:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_result(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        exp_q.push_back({a, b, op});
    endtask

    // One-cycle key strobe; returns 1 time unit after the capturing edge.
    task automatic press(input logic [3:0] code);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got a=0x%0h b=0x%0h op=%0d, expected no transfer",
                         bus.a, bus.b, bus.op);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("xfer_a",  32'(bus.a),  32'(e[33:18]));
                check("xfer_b",  32'(bus.b),  32'(e[17:2]));
                check("xfer_op", 32'(bus.op), 32'(e[1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.out_ready = 1'b1;
        idle(2);
        check("rst_a",         32'(bus.a),         32'h0);
        check("rst_b",         32'(bus.b),         32'h0);
        check("rst_op",        32'(bus.op),        32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_ovf",       32'(bus.ovf),       32'h0);
        check("rst_err",       32'(bus.err),       32'h0);
        check("rst_state",     32'(bus.state_o),   32'h0);
        rst = 1'b0;

        // Basic "12" op0 "4" commit.
        press(4'd0); press(4'd1); press(4'd3);
        check("t1_state_b", 32'(bus.state_o), 32'h1);
        press(4'd4);
        expect_result(16'h0012, 16'h0004, 2'd0);
        press(4'd14);
        check("t1_valid", 32'(bus.out_valid), 32'h1);
        check("t1_a",     32'(bus.a),         32'h0012);
        check("t1_b",     32'(bus.b),         32'h0004);
        check("t1_state", 32'(bus.state_o),   32'h0);

        // Fifth digit into A is dropped and sets ovf; commit clears ovf.
        press(4'd0); press(4'd1); press(4'd2); press(4'd4);
        check("t2_ovf_full", 32'(bus.ovf), 32'h0);
        press(4'd5);
        check("t2_ovf_set", 32'(bus.ovf), 32'h1);
        press(4'd3); press(4'd0);
        expect_result(16'h1234, 16'h0001, 2'd0);
        press(4'd14);
        check("t2_a",       32'(bus.a),   32'h1234);
        check("t2_ovf_clr", 32'(bus.ovf), 32'h0);

        // Backspace out of an empty B, then empty A, then a no-op backspace.
        press(4'd8); press(4'd7);
        check("t3_state_b", 32'(bus.state_o), 32'h1);
        press(4'd12);
        check("t3_back_to_a", 32'(bus.state_o), 32'h0);
        press(4'd12);
        press(4'd12);
        check("t3_noop_state", 32'(bus.state_o), 32'h0);
        check("t3_noop_err",   32'(bus.err),     32'h0);
        press(4'd11); press(4'd10);
        expect_result(16'h0000, 16'h0009, 2'd2);
        press(4'd14);
        check("t3_a", 32'(bus.a), 32'h0);

        // Backpressure: second commit is rejected while the first is held.
        idle(1);
        bus.out_ready = 1'b0;
        press(4'd1); press(4'd7); press(4'd2);
        expect_result(16'h0002, 16'h0003, 2'd1);
        press(4'd14);
        check("t4_valid1", 32'(bus.out_valid), 32'h1);
        check("t4_a1",     32'(bus.a),         32'h0002);
        press(4'd4); press(4'd15); press(4'd5);
        press(4'd14);
        check("t4_err",      32'(bus.err),       32'h1);
        check("t4_hold_a",   32'(bus.a),         32'h0002);
        check("t4_hold_b",   32'(bus.b),         32'h0003);
        check("t4_hold_op",  32'(bus.op),        32'h1);
        check("t4_hold_val", 32'(bus.out_valid), 32'h1);
        idle(1);
        check("t4_err_pulse", 32'(bus.err), 32'h0);
        check("t4_stable_a",  32'(bus.a),   32'h0002);
        bus.out_ready = 1'b1;
        expect_result(16'h0004, 16'h0005, 2'd3);
        press(4'd14);
        check("t4_valid2", 32'(bus.out_valid), 32'h1);
        check("t4_a2",     32'(bus.a),         32'h0004);
        check("t4_op2",    32'(bus.op),        32'h3);

        // Commit in ENT_A is rejected; async reset mid-entry of B.
        idle(1);
        press(4'd14);
        check("t5_err",   32'(bus.err),       32'h1);
        check("t5_valid", 32'(bus.out_valid), 32'h0);
        check("t5_a",     32'(bus.a),         32'h0004);
        press(4'd0); press(4'd1); press(4'd2); press(4'd4); press(4'd5);
        press(4'd3); press(4'd8);
        check("t5_pre_state", 32'(bus.state_o), 32'h1);
        check("t5_pre_ovf",   32'(bus.ovf),     32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_a",     32'(bus.a),         32'h0);
        check("t5_rst_b",     32'(bus.b),         32'h0);
        check("t5_rst_op",    32'(bus.op),        32'h0);
        check("t5_rst_valid", 32'(bus.out_valid), 32'h0);
        check("t5_rst_ovf",   32'(bus.ovf),       32'h0);
        check("t5_rst_state", 32'(bus.state_o),   32'h0);
        idle(2);
        rst = 1'b0;
        press(4'd2); press(4'd15); press(4'd13);
        expect_result(16'h0003, 16'h0000, 2'd3);
        press(4'd14);
        check("t5_post_a", 32'(bus.a), 32'h0003);

        // Drain: every expected result must have been observed.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
